// File: rtl/dram_ctrl.sv
// Purpose: RAS/CAS/WE/MUX sequencer for the slot-3 main RAM (8x 64Kx1), with an 8-bit refresh row counter.
// Latency: strobes sampled into s_*, RAS falls 2 edges after a start condition; strobes inactive 2 edges after nmreq rises.
// Backpressure: none; the Z80 bus is sampled every clock and the cycle length follows nmreq.
//
// Ports:
//   clk, nreset                       master clock, async active-low reset
//   nmreq, nrd, nwr, nrfsh, nsltsl3   Z80 strobes and slot-3 select (active-low)
//   addr[15:0]                        Z80 address bus (row = [7:0], column = [15:8])
//   nras, ncas, nwe, mux              registered DRAM strobes / address-phase select
//   dram_addr[7:0]                    multiplexed DRAM address
//   ref_row[7:0]                      refresh row counter (all 256 rows)
module dram_ctrl #(
  parameter int TRP      = 2,  // precharge cycles, >= 1, <= 255
  parameter int TRAS_REF = 3   // minimum RAS-low cycles in refresh, >= 1, <= 255
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        nmreq,
  input  logic        nrd,
  input  logic        nwr,
  input  logic        nrfsh,
  input  logic        nsltsl3,
  input  logic [15:0] addr,
  output logic        nras,
  output logic        ncas,
  output logic        nwe,
  output logic        mux,
  output logic [7:0]  dram_addr,
  output logic [7:0]  ref_row
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ROW  = 3'd1;
  localparam logic [2:0] ST_COL  = 3'd2;
  localparam logic [2:0] ST_CAS  = 3'd3;
  localparam logic [2:0] ST_REF  = 3'd4;
  localparam logic [2:0] ST_PRE  = 3'd5;

  logic [2:0]  state;
  logic [7:0]  cyc_cnt;  // RAS-low cycles in REF, elapsed cycles in PRE
  logic        s_nmreq, s_nrd, s_nwr, s_nrfsh, s_nsltsl3;
  logic [15:0] s_addr;

  // Refresh drives the internal row counter: the Z80 refresh address only spans 128 rows.
  always_comb begin
    dram_addr = s_addr[7:0];
    if (state == ST_REF)
      dram_addr = ref_row;
    else if (mux)
      dram_addr = s_addr[15:8];
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      s_nmreq   <= 1'b1;
      s_nrd     <= 1'b1;
      s_nwr     <= 1'b1;
      s_nrfsh   <= 1'b1;
      s_nsltsl3 <= 1'b1;
      s_addr    <= 16'h0000;
      state     <= ST_IDLE;
      cyc_cnt   <= 8'd0;
      nras      <= 1'b1;
      ncas      <= 1'b1;
      nwe       <= 1'b1;
      mux       <= 1'b0;
      ref_row   <= 8'd0;
    end else begin
      s_nmreq   <= nmreq;
      s_nrd     <= nrd;
      s_nwr     <= nwr;
      s_nrfsh   <= nrfsh;
      s_nsltsl3 <= nsltsl3;
      s_addr    <= addr;

      case (state)
        ST_IDLE: begin
          // Refresh wins over a slot-3 access; the cycle type is locked in here.
          if (!s_nmreq && !s_nrfsh) begin
            state   <= ST_REF;
            nras    <= 1'b0;
            ncas    <= 1'b1;
            mux     <= 1'b0;
            cyc_cnt <= 8'd1;
          end else if (!s_nmreq && !s_nsltsl3) begin
            state <= ST_ROW;
            nras  <= 1'b0;
            mux   <= 1'b0;
          end
        end

        ST_ROW: begin
          state <= ST_COL;
          mux   <= 1'b1;
        end

        ST_COL: begin
          if (s_nmreq) begin
            state   <= ST_PRE;
            nras    <= 1'b1;
            ncas    <= 1'b1;
            nwe     <= 1'b1;
            mux     <= 1'b0;
            cyc_cnt <= 8'd1;
          end else if (!s_nrd || !s_nwr) begin
            // Early write: WE settles together with CAS. RD+WR both low is taken as a write.
            state <= ST_CAS;
            ncas  <= 1'b0;
            nwe   <= s_nwr;
          end
        end

        ST_CAS: begin
          if (s_nmreq) begin
            state   <= ST_PRE;
            nras    <= 1'b1;
            ncas    <= 1'b1;
            nwe     <= 1'b1;
            mux     <= 1'b0;
            cyc_cnt <= 8'd1;
          end
        end

        ST_REF: begin
          if (cyc_cnt >= 8'(TRAS_REF) && s_nmreq) begin
            state   <= ST_PRE;
            nras    <= 1'b1;
            ncas    <= 1'b1;
            nwe     <= 1'b1;
            mux     <= 1'b0;
            cyc_cnt <= 8'd1;
            ref_row <= ref_row + 8'd1;
          end else if (cyc_cnt < 8'(TRAS_REF)) begin
            cyc_cnt <= cyc_cnt + 8'd1;
          end
        end

        ST_PRE: begin
          if (cyc_cnt >= 8'(TRP))
            state <= ST_IDLE;
          else
            cyc_cnt <= cyc_cnt + 8'd1;
        end

        default: begin
          state <= ST_IDLE;
          nras  <= 1'b1;
          ncas  <= 1'b1;
          nwe   <= 1'b1;
          mux   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dram_ctrl.sv
// Purpose: directed self-checking bench for dram_ctrl (read, write, slot miss, abort, refresh, async reset).
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable; the bench drives the bus strobes directly.
module tb_dram_ctrl;

  logic        clk = 1'b0;
  logic        nreset;
  logic        nmreq, nrd, nwr, nrfsh, nsltsl3;
  logic [15:0] addr;
  logic        nras, ncas, nwe, mux;
  logic [7:0]  dram_addr, ref_row;

  int checks   = 0;
  int failures = 0;

  // Protocol watchers, evaluated on the falling edge.
  int we_without_cas = 0;  // nwe low while ncas high
  int we_toggle_cas  = 0;  // nwe changed while ncas stayed low
  logic prev_ncas = 1'b1;
  logic prev_nwe  = 1'b1;

  dram_ctrl #(.TRP(2), .TRAS_REF(3)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .nmreq     (nmreq),
    .nrd       (nrd),
    .nwr       (nwr),
    .nrfsh     (nrfsh),
    .nsltsl3   (nsltsl3),
    .addr      (addr),
    .nras      (nras),
    .ncas      (ncas),
    .nwe       (nwe),
    .mux       (mux),
    .dram_addr (dram_addr),
    .ref_row   (ref_row)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (nwe == 1'b0 && ncas == 1'b1) we_without_cas++;
    if (prev_ncas == 1'b0 && ncas == 1'b0 && nwe != prev_nwe) we_toggle_cas++;
    prev_ncas = ncas;
    prev_nwe  = nwe;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    nmreq = 1'b1; nrd = 1'b1; nwr = 1'b1; nrfsh = 1'b1;
  endtask

  initial begin
    logic cas_seen;
    logic ras_seen;
    int   low_cnt;

    nreset = 1'b0; nsltsl3 = 1'b0; addr = 16'h0000;
    bus_idle();

    // ---- reset state ----
    tick(); tick();
    chk("rst_nras", nras, 1); chk("rst_ncas", ncas, 1); chk("rst_nwe", nwe, 1);
    chk("rst_mux", mux, 0);   chk("rst_ref_row", ref_row, 0);
    nreset = 1'b1;
    tick(); tick();

    // ---- read 0x1234 ----
    addr = 16'h1234; nmreq = 1'b0; nrd = 1'b0;
    tick(); chk("rd_e1_nras", nras, 1);
    tick(); chk("rd_row_nras", nras, 0); chk("rd_row_mux", mux, 0);
            chk("rd_row_addr", dram_addr, 8'h34); chk("rd_row_ncas", ncas, 1);
    tick(); chk("rd_col_mux", mux, 1); chk("rd_col_addr", dram_addr, 8'h12);
            chk("rd_col_ncas", ncas, 1);
    tick(); chk("rd_cas_ncas", ncas, 0); chk("rd_cas_nwe", nwe, 1);
    repeat (6) tick();
    chk("rd_hold_ncas", ncas, 0); chk("rd_hold_nwe", nwe, 1);
    bus_idle();
    tick(); chk("rd_end1_nras", nras, 0);
    tick(); chk("rd_end2_nras", nras, 1); chk("rd_end2_ncas", ncas, 1);
            chk("rd_end2_nwe", nwe, 1);   chk("rd_end2_mux", mux, 0);
    tick(); chk("rd_pre2_nras", nras, 1); chk("rd_pre2_ncas", ncas, 1);
    repeat (2) tick();

    // ---- write at 0x1234, nwr falls 3 master cycles after nmreq ----
    addr = 16'h1234; nmreq = 1'b0;
    tick(); tick();
    chk("wr_row_nras", nras, 0);
    tick(); chk("wr_col_mux", mux, 1); chk("wr_col_ncas", ncas, 1); chk("wr_col_nwe", nwe, 1);
    nwr = 1'b0;
    tick(); chk("wr_wait_ncas", ncas, 1); chk("wr_wait_nwe", nwe, 1);
    tick(); chk("wr_cas_ncas", ncas, 0); chk("wr_cas_nwe", nwe, 0);
    repeat (4) tick();
    bus_idle();
    tick(); tick();
    chk("wr_end_nras", nras, 1); chk("wr_end_ncas", ncas, 1); chk("wr_end_nwe", nwe, 1);
    repeat (3) tick();

    // ---- rd and wr both low: treated as write ----
    addr = 16'h0F0F; nmreq = 1'b0; nrd = 1'b0; nwr = 1'b0;
    repeat (4) tick();
    chk("rdwr_ncas", ncas, 0); chk("rdwr_nwe", nwe, 0);
    bus_idle();
    repeat (5) tick();

    // ---- slot 3 not selected ----
    nsltsl3 = 1'b1; addr = 16'hBEEF; nmreq = 1'b0; nrd = 1'b0;
    ras_seen = 1'b0; cas_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!nras) ras_seen = 1'b1;
      if (!ncas) cas_seen = 1'b1;
    end
    chk("noslot_ras_low", ras_seen, 0); chk("noslot_cas_low", cas_seen, 0);
    bus_idle(); nsltsl3 = 1'b0;
    repeat (3) tick();

    // ---- aborted cycle: 1-cycle nmreq pulse, no rd/wr ----
    addr = 16'h5AA5; nmreq = 1'b0;
    tick(); nmreq = 1'b1; cas_seen = 1'b0;
    tick(); chk("abort_row_nras", nras, 0); chk("abort_row_mux", mux, 0);
    tick(); chk("abort_col_mux", mux, 1); chk("abort_col_addr", dram_addr, 8'h5A);
    if (!ncas) cas_seen = 1'b1;
    tick(); chk("abort_pre_nras", nras, 1); chk("abort_pre_mux", mux, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (!ncas) cas_seen = 1'b1;
    end
    chk("abort_cas_low", cas_seen, 0);

    // ---- 257 refresh cycles, 6 master cycles of nmreq/nrfsh each ----
    cas_seen = 1'b0;
    for (int n = 0; n < 257; n++) begin
      addr = 16'(n & 8'h7F); nmreq = 1'b0; nrfsh = 1'b0;
      tick(); tick();
      chk("ref_nras", nras, 0);
      chk("ref_addr", dram_addr, 32'(n % 256));
      for (int i = 0; i < 4; i++) begin
        tick();
        if (!ncas) cas_seen = 1'b1;
      end
      bus_idle();
      for (int i = 0; i < 5; i++) begin
        tick();
        if (!ncas) cas_seen = 1'b1;
      end
    end
    chk("ref_ras_only", cas_seen, 0);
    chk("ref_row_wrap", ref_row, 1);

    // ---- short refresh pulse still keeps RAS low TRAS_REF cycles ----
    nmreq = 1'b0; nrfsh = 1'b0;
    tick(); bus_idle();
    low_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!nras) low_cnt++;
      if (i == 1) chk("ref_short_addr", dram_addr, 1);
    end
    chk("ref_short_ras_cycles", low_cnt, 3);
    chk("ref_short_row", ref_row, 2);

    // ---- async reset in the middle of a write ----
    addr = 16'h1234; nmreq = 1'b0; nwr = 1'b0;
    repeat (4) tick();
    chk("rstw_ncas_low", ncas, 0);
    #3 nreset = 1'b0;
    #1;
    chk("rstw_nras", nras, 1); chk("rstw_ncas", ncas, 1); chk("rstw_nwe", nwe, 1);
    chk("rstw_mux", mux, 0);   chk("rstw_ref_row", ref_row, 0);
    bus_idle();
    tick(); tick();
    #2 nreset = 1'b1;
    tick();
    addr = 16'h5678; nmreq = 1'b0; nrd = 1'b0;
    tick(); chk("post_e1_nras", nras, 1);
    tick(); chk("post_row_nras", nras, 0); chk("post_row_addr", dram_addr, 8'h78);
    tick(); chk("post_col_addr", dram_addr, 8'h56); chk("post_col_mux", mux, 1);
    tick(); chk("post_cas_ncas", ncas, 0); chk("post_cas_nwe", nwe, 1);
    bus_idle();
    repeat (4) tick();
    chk("post_end_nras", nras, 1);

    chk("we_without_cas", we_without_cas, 0);
    chk("we_toggle_cas", we_toggle_cas, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
